mmio_responder: RTL and testbench
=================================

# mmio_responder

Memory-mapped peripheral responder on the processor's data-memory bus (memoryAddress / writeData / memoryWriteEnable / readData), the device side of the accesses the multi-cycle MIPS core issues. Decodes a 64-byte window at BASE_ADDR and provides an LED output register, a free-running cycle counter and a down-counting timer with a sticky expiry flag and interrupt line. The top level selects this block's read data instead of the memory's read data whenever `hit` is high. Writes are suppressed at the memory by the same `hit`.

## Interface
- BASE_ADDR, 32'hFFFF_0000: window base. Hit when memoryAddress[31:6] == BASE_ADDR[31:6].
- LED_WIDTH, 8: width of LED register, 1..32.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- memoryAddress  input  32  byte address from core; bits [1:0] ignored.
- writeData  input  32  store data.
- memoryWriteEnable  input  1  store strobe; write occurs at the clk edge when high and `hit`.
- readData  output  32  register read value, combinational from address and registered state; 0 when not `hit`.
- hit  output  1  combinational address-window match.
- ledOut  output  LED_WIDTH  LED register contents.
- timerIrq  output  1  level interrupt, equals STATUS.expired.

## Operation
- Register map, byte offset = memoryAddress[5:2]*4:
  - 0x00 LED: RW, bits [LED_WIDTH-1:0]; upper bits read 0.
  - 0x04 CYCLE: RO; writes ignored.
  - 0x08 TLOAD: RW, 32-bit reload value.
  - 0x0C TCTRL: RW. Bit0 EN, bit1 AUTO; other bits read 0.
  - 0x10 TCOUNT: RO, current count.
  - 0x14 STATUS: bit0 EXPIRED. Write 1 to clear; writing 0 has no effect.
  - 0x18..0x3C: read 0, writes ignored.
- Timer FSM, states IDLE and RUN:
  - Any write to TCTRL with EN=1 loads TCOUNT<=TLOAD and enters RUN. This also restarts the timer if it is already running.
  - A write with EN=0 enters IDLE. TCOUNT holds its value.
  - In RUN, when TCOUNT != 0, TCOUNT decrements by 1.
  - In RUN, when TCOUNT == 0, EXPIRED<=1. Then:
    - AUTO=1: TCOUNT<=TLOAD and stay in RUN.
    - AUTO=0: clear EN and go to IDLE.
  - Period is therefore TLOAD+1 cycles. TLOAD=0 expires every cycle in AUTO mode.
- A TLOAD write during RUN does not affect TCOUNT until the next reload or start.
- If a hardware set of EXPIRED and a software clear fall in the same cycle, the set wins.
- A TCTRL write and a terminal count in the same cycle: the write wins for state and TCOUNT. EXPIRED is still set.
- CYCLE increments every cycle and wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values: LED=0, CYCLE=0, TLOAD=0, TCTRL=0, TCOUNT=0, EXPIRED=0, FSM=IDLE. Consequently ledOut=0 and timerIrq=0. readData/hit follow the address.
- Reset mid-count aborts immediately. No expiry is generated.
- Reads: zero latency, combinational within the same cycle. They have no side effects.
- Writes: visible on readData and outputs from the cycle after the edge.
- timerIrq rises in the cycle after the edge at which TCOUNT==0 was observed in RUN.
- CYCLE read value equals the number of rising edges since reset release, modulo 2^32.

## Configuration
- MMIO_CYCLE_COUNTER_EN defined: CYCLE register implemented as above.
- Not defined: no counter flops are instantiated. Offset 0x04 reads 0 and writes are ignored. All other behaviour is unchanged.

## Structure
- Package mmio_pkg holds:
  - register offset localparams (OFS_LED, OFS_CYCLE, OFS_TLOAD, OFS_TCTRL, OFS_TCOUNT, OFS_STATUS);
  - TCTRL/STATUS bit index constants;
  - the enum timer_state_t {T_IDLE, T_RUN}.
- One sub-module, mmio_timer. It owns TLOAD, TCTRL, TCOUNT, EXPIRED and the FSM, and receives decoded write strobes and writeData from the top.
- Address decode, LED, CYCLE and the read mux stay in mmio_responder.

## Test plan
- Reset low, then release: all reads 0, ledOut=0, timerIrq=0. With the macro defined, CYCLE read 10 cycles later returns 10.
- Write 32'h0000_00A5 to BASE+0x00, then read: ledOut=8'hA5 and readData=32'hA5. Writing to address BASE+0x40 leaves hit=0 and ledOut unchanged.
- TLOAD=3, TCTRL=1 (one-shot): timerIrq rises exactly 4 cycles after the TCTRL write edge. TCTRL then reads 0 and TCOUNT stays 0. Writing STATUS=1 drops timerIrq the next cycle.
- TLOAD=2, TCTRL=3 (auto): EXPIRED is set every 3 cycles. A STATUS clear issued in the same cycle as an expiry leaves timerIrq=1.
- Running timer with TCOUNT=5: write TLOAD=100. TCOUNT continues 4,3,…; the reload after expiry loads 100.
- Assert reset while TCOUNT=2 in RUN: immediately FSM=IDLE and TCOUNT=0, with no timerIrq pulse.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder: register offsets, control/status
// bit positions and the timer state encoding.
package mmio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFS_W  = 6;

  // Byte offsets inside the 64-byte window
  localparam logic [OFS_W-1:0] OFS_LED    = 6'h00;
  localparam logic [OFS_W-1:0] OFS_CYCLE  = 6'h04;
  localparam logic [OFS_W-1:0] OFS_TLOAD  = 6'h08;
  localparam logic [OFS_W-1:0] OFS_TCTRL  = 6'h0C;
  localparam logic [OFS_W-1:0] OFS_TCOUNT = 6'h10;
  localparam logic [OFS_W-1:0] OFS_STATUS = 6'h14;

  localparam int unsigned TCTRL_EN_BIT       = 0;
  localparam int unsigned TCTRL_AUTO_BIT     = 1;
  localparam int unsigned STATUS_EXPIRED_BIT = 0;

  typedef enum logic [0:0] {
    T_IDLE = 1'b0,
    T_RUN  = 1'b1
  } timer_state_t;

endpackage

// File: rtl/mmio_timer.sv
// Down-counting timer: TLOAD/TCTRL/TCOUNT registers, sticky EXPIRED flag and
// the IDLE/RUN state machine. Driven by decoded write strobes from the top.
module mmio_timer
  import mmio_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wdata,
  input  logic              tload_we,
  input  logic              tctrl_we,
  input  logic              status_we,
  output logic [DATA_W-1:0] tload,
  output logic [DATA_W-1:0] tctrl,
  output logic [DATA_W-1:0] tcount,
  output logic              expired
);

  timer_state_t      state_q, state_d;
  logic [DATA_W-1:0] tload_q;
  logic [DATA_W-1:0] tcount_q, tcount_d;
  logic              auto_q, auto_d;
  logic              expired_q, expired_d;
  logic              terminal;

  assign terminal = (state_q == T_RUN) && (tcount_q == '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= T_IDLE;
    else        state_q <= state_d;
  end

  // Next state: a TCTRL write overrides the terminal-count transition
  always_comb begin
    state_d = state_q;
    if (tctrl_we) begin
      state_d = wdata[TCTRL_EN_BIT] ? T_RUN : T_IDLE;
    end else if (terminal && !auto_q) begin
      state_d = T_IDLE;
    end
  end

  // Datapath next values; hardware expiry beats a same-cycle software clear
  always_comb begin
    tcount_d  = tcount_q;
    auto_d    = auto_q;
    expired_d = expired_q;
    if (status_we && wdata[STATUS_EXPIRED_BIT]) expired_d = 1'b0;
    if (terminal) expired_d = 1'b1;
    if (tctrl_we) begin
      auto_d = wdata[TCTRL_AUTO_BIT];
      if (wdata[TCTRL_EN_BIT]) tcount_d = tload_q;
    end else if (state_q == T_RUN) begin
      if (tcount_q != '0) tcount_d = tcount_q - DATA_W'(1);
      else if (auto_q)    tcount_d = tload_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tload_q   <= '0;
      tcount_q  <= '0;
      auto_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      if (tload_we) tload_q <= wdata;
      tcount_q  <= tcount_d;
      auto_q    <= auto_d;
      expired_q <= expired_d;
    end
  end

  // Register read-back words; EN mirrors the RUN state
  always_comb begin
    tctrl                 = '0;
    tctrl[TCTRL_EN_BIT]   = (state_q == T_RUN);
    tctrl[TCTRL_AUTO_BIT] = auto_q;
  end

  assign tload   = tload_q;
  assign tcount  = tcount_q;
  assign expired = expired_q;

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped peripheral responder: 64-byte window with LED register,
// optional free-running cycle counter and a down-counting timer.
// Optional feature macro: MMIO_CYCLE_COUNTER_EN (implements the CYCLE register).
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int unsigned LED_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          memoryAddress,
  input  logic [31:0]          writeData,
  input  logic                 memoryWriteEnable,
  output logic [31:0]          readData,
  output logic                 hit,
  output logic [LED_WIDTH-1:0] ledOut,
  output logic                 timerIrq
);

  logic [OFS_W-1:0]     offset;
  logic                 wr_en;
  logic [LED_WIDTH-1:0] led_q;
  logic [DATA_W-1:0]    cycle_val;
  logic [DATA_W-1:0]    tload, tctrl, tcount;
  logic [DATA_W-1:0]    status_word;
  logic                 expired;
  logic [1:0]           unused_addr_bits;

  assign hit              = (memoryAddress[31:6] == BASE_ADDR[31:6]);
  assign offset           = {memoryAddress[5:2], 2'b00};
  assign wr_en            = memoryWriteEnable && hit;
  assign unused_addr_bits = memoryAddress[1:0];

  // LED output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) led_q <= '0;
    else if (wr_en && (offset == OFS_LED)) led_q <= writeData[LED_WIDTH-1:0];
  end

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [DATA_W-1:0] cycle_q;

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycle_q <= '0;
    else        cycle_q <= cycle_q + DATA_W'(1);
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = '0;
`endif

  mmio_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .wdata     (writeData),
    .tload_we  (wr_en && (offset == OFS_TLOAD)),
    .tctrl_we  (wr_en && (offset == OFS_TCTRL)),
    .status_we (wr_en && (offset == OFS_STATUS)),
    .tload     (tload),
    .tctrl     (tctrl),
    .tcount    (tcount),
    .expired   (expired)
  );

  // STATUS read-back word
  always_comb begin
    status_word                     = '0;
    status_word[STATUS_EXPIRED_BIT] = expired;
  end

  // Read mux: zero outside the window and for unmapped offsets
  always_comb begin
    readData = '0;
    if (hit) begin
      case (offset)
        OFS_LED:    readData = DATA_W'(led_q);
        OFS_CYCLE:  readData = cycle_val;
        OFS_TLOAD:  readData = tload;
        OFS_TCTRL:  readData = tctrl;
        OFS_TCOUNT: readData = tcount;
        OFS_STATUS: readData = status_word;
        default:    readData = '0;
      endcase
    end
  end

  assign ledOut   = led_q;
  assign timerIrq = expired;

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: reset checks, a vector table,
// directed timer corner cases and randomized traffic against a reference model.
module tb_mmio_responder;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int unsigned LED_W = 8;

  logic             clk;
  logic             reset;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic             we;
  logic [31:0]      rdata;
  logic             hit;
  logic [LED_W-1:0] led;
  logic             irq;

  int unsigned n_cmp;
  int unsigned n_err;

  mmio_responder #(.BASE_ADDR(BASE), .LED_WIDTH(LED_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .memoryAddress     (addr),
    .writeData         (wdata),
    .memoryWriteEnable (we),
    .readData          (rdata),
    .hit               (hit),
    .ledOut            (led),
    .timerIrq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] ofs, input logic [31:0] d);
    addr  = BASE | 32'(ofs);
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rdchk(input string name, input logic [5:0] ofs, input logic [31:0] exp);
    addr = BASE | 32'(ofs);
    we   = 1'b0;
    #1;
    chk(name, rdata, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_led, m_cycle, m_tload, m_count;
  logic        m_run, m_auto, m_exp;

  task automatic model_reset();
    m_led = 0; m_cycle = 0; m_tload = 0; m_count = 0;
    m_run = 0; m_auto = 0; m_exp = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:6] != BASE[31:6]) return 32'h0;
    case (a[5:2])
      4'd0: return m_led;
`ifdef MMIO_CYCLE_COUNTER_EN
      4'd1: return m_cycle;
`endif
      4'd2: return m_tload;
      4'd3: return {30'h0, m_auto, m_run};
      4'd4: return m_count;
      4'd5: return {31'h0, m_exp};
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge: old values decide, writes and timer rules applied together
  task automatic model_step(input logic w_en, input logic [31:0] a, input logic [31:0] d);
    logic        w;
    int          reg_idx;
    logic        expiring;
    logic [31:0] old_tload;
    w         = w_en && (a[31:6] == BASE[31:6]);
    reg_idx   = int'(a[5:2]);
    expiring  = m_run && (m_count == 0);
    old_tload = m_tload;
    if (w && reg_idx == 5 && d[0]) m_exp = 1'b0;
    if (expiring) m_exp = 1'b1;
    if (w && reg_idx == 3) begin
      m_auto = d[1];
      if (d[0]) begin m_run = 1'b1; m_count = old_tload; end
      else m_run = 1'b0;
    end else if (m_run) begin
      if (m_count != 0) m_count = m_count - 1;
      else if (m_auto) m_count = old_tload;
      else m_run = 1'b0;
    end
    if (w && reg_idx == 2) m_tload = d;
    if (w && reg_idx == 0) m_led = d & ((32'h1 << LED_W) - 1);
    m_cycle = m_cycle + 1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_hit;
    logic [7:0]  exp_led;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] r, input logic h, input logic [7:0] l);
    vec_t v;
    v.we = w; v.addr = a; v.data = d; v.exp_rd = r; v.exp_hit = h; v.exp_led = l;
    return v;
  endfunction

  initial begin
    logic [31:0] exp_cycle;
    logic [31:0] ra, rd;
    logic        rw;
    n_cmp = 0;
    n_err = 0;
    clk   = 1'b0;
    reset = 1'b1;
    addr  = BASE;
    wdata = 0;
    we    = 1'b0;

    // reset state
    #1 reset = 1'b0;
    tick(); tick();
    for (int i = 0; i < 16; i++) rdchk($sformatf("rst.rd%0d", i), 6'(i * 4), 32'h0);
    chk("rst.led", 32'(led), 32'h0);
    chk("rst.irq", 32'(irq), 32'h0);
    chk("rst.hit", 32'(hit), 32'h1);
    reset = 1'b1;

    // cycle counter: 10 edges after release
`ifdef MMIO_CYCLE_COUNTER_EN
    exp_cycle = 32'd10;
`else
    exp_cycle = 32'd0;
`endif
    repeat (10) tick();
    rdchk("cycle10", 6'h04, exp_cycle);
    wr(6'h04, 32'h0);
`ifdef MMIO_CYCLE_COUNTER_EN
    exp_cycle = 32'd11;
`endif
    rdchk("cycle.ro", 6'h04, exp_cycle);

    // vector table (checks are pre-edge; writes land at the edge)
    vecs[0]  = mk(0, BASE + 32'h00, 32'h0,        32'h0,  1, 8'h00);
    vecs[1]  = mk(1, BASE + 32'h00, 32'h0000_00A5, 32'h0, 1, 8'h00);
    vecs[2]  = mk(0, BASE + 32'h00, 32'h0,        32'hA5, 1, 8'hA5);
    vecs[3]  = mk(1, BASE + 32'h40, 32'h33,       32'h0,  0, 8'hA5);
    vecs[4]  = mk(0, BASE + 32'h01, 32'h0,        32'hA5, 1, 8'hA5);
    vecs[5]  = mk(1, BASE + 32'h08, 32'h7,        32'h0,  1, 8'hA5);
    vecs[6]  = mk(0, BASE + 32'h0B, 32'h0,        32'h7,  1, 8'hA5);
    vecs[7]  = mk(1, BASE + 32'h18, 32'hFFFF_FFFF, 32'h0, 1, 8'hA5);
    vecs[8]  = mk(0, BASE + 32'h18, 32'h0,        32'h0,  1, 8'hA5);
    vecs[9]  = mk(0, BASE + 32'h0C, 32'h0,        32'h0,  1, 8'hA5);
    vecs[10] = mk(1, BASE + 32'h00, 32'h1FF,      32'hA5, 1, 8'hA5);
    vecs[11] = mk(0, BASE + 32'h00, 32'h0,        32'hFF, 1, 8'hFF);
    vecs[12] = mk(0, 32'h0000_0000, 32'h0,        32'h0,  0, 8'hFF);
    vecs[13] = mk(0, BASE + 32'h14, 32'h0,        32'h0,  1, 8'hFF);
    vecs[14] = mk(0, BASE + 32'h3C, 32'h0,        32'h0,  1, 8'hFF);
    for (int i = 0; i < NV; i++) begin
      addr = vecs[i].addr; wdata = vecs[i].data; we = vecs[i].we;
      #1;
      chk($sformatf("vec%0d.rd", i), rdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d.hit", i), 32'(hit), 32'(vecs[i].exp_hit));
      chk($sformatf("vec%0d.led", i), 32'(led), 32'(vecs[i].exp_led));
      @(posedge clk); #1;
      we = 1'b0;
    end

    // A: one-shot, TLOAD=3 -> irq 4 edges after the TCTRL write
    wr(6'h08, 32'd3);
    wr(6'h0C, 32'd1);
    rdchk("A.cnt0", 6'h10, 32'd3);
    chk("A.irq0", 32'(irq), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("A.irq%0d", k), 32'(irq), (k == 4) ? 32'h1 : 32'h0);
    end
    rdchk("A.tctrl", 6'h0C, 32'h0);
    rdchk("A.cnt", 6'h10, 32'h0);
    tick();
    rdchk("A.cnt.hold", 6'h10, 32'h0);
    chk("A.sticky", 32'(irq), 32'h1);
    wr(6'h14, 32'h0);
    chk("A.clr0", 32'(irq), 32'h1);
    wr(6'h14, 32'h1);
    chk("A.clr1", 32'(irq), 32'h0);

    // B: auto mode, TLOAD=2 -> expiry every 3 edges; set beats clear
    wr(6'h08, 32'd2);
    wr(6'h0C, 32'd3);
    tick(); tick();
    chk("B.e2", 32'(irq), 32'h0);
    tick();
    chk("B.e3", 32'(irq), 32'h1);
    wr(6'h14, 32'h1);
    chk("B.e4", 32'(irq), 32'h0);
    tick();
    chk("B.e5", 32'(irq), 32'h0);
    tick();
    chk("B.e6", 32'(irq), 32'h1);
    wr(6'h14, 32'h1);
    chk("B.e7", 32'(irq), 32'h0);
    tick();
    rdchk("B.cnt8", 6'h10, 32'h0);
    wr(6'h14, 32'h1);
    chk("B.setwins", 32'(irq), 32'h1);
    rdchk("B.reload", 6'h10, 32'd2);
    wr(6'h0C, 32'h0);
    wr(6'h14, 32'h1);
    chk("B.stop", 32'(irq), 32'h0);

    // C: TLOAD write while running only matters at the next reload
    wr(6'h08, 32'd5);
    wr(6'h0C, 32'd3);
    wr(6'h08, 32'd100);
    rdchk("C.cnt4", 6'h10, 32'd4);
    begin
      logic [31:0] seq_c [6];
      seq_c = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd100, 32'd99};
      for (int k = 0; k < 6; k++) begin
        tick();
        rdchk($sformatf("C.cnt%0d", k), 6'h10, seq_c[k]);
      end
    end
    wr(6'h0C, 32'h0);
    wr(6'h14, 32'h1);

    // D: reset mid-count aborts with no expiry
    wr(6'h08, 32'd5);
    wr(6'h0C, 32'd1);
    tick(); tick(); tick();
    rdchk("D.cnt2", 6'h10, 32'd2);
    reset = 1'b0;
    #1;
    rdchk("D.cnt.rst", 6'h10, 32'h0);
    rdchk("D.tctrl.rst", 6'h0C, 32'h0);
    chk("D.irq.rst", 32'(irq), 32'h0);
    repeat (4) begin
      tick();
      chk("D.irq.held", 32'(irq), 32'h0);
    end
    reset = 1'b1;
    repeat (5) begin
      tick();
      chk("D.irq.after", 32'(irq), 32'h0);
    end
    rdchk("D.cnt.after", 6'h10, 32'h0);

    // E: TCTRL write on the terminal-count edge wins, expiry still set
    wr(6'h08, 32'd1);
    wr(6'h0C, 32'd1);
    tick();
    rdchk("E.cnt0", 6'h10, 32'h0);
    wr(6'h0C, 32'd1);
    chk("E.irq", 32'(irq), 32'h1);
    rdchk("E.tctrl", 6'h0C, 32'h1);
    rdchk("E.cnt", 6'h10, 32'h1);
    tick(); tick();
    rdchk("E.done", 6'h0C, 32'h0);
    wr(6'h14, 32'h1);
    chk("E.clr", 32'(irq), 32'h0);

    // Randomized traffic against the reference model
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    for (int n = 0; n < 500; n++) begin
      int unsigned ofs;
      ofs = $urandom_range(0, 15);
      if ($urandom_range(0, 9) == 0)
        ra = (BASE ^ (32'h1 << $urandom_range(6, 31))) | 32'($urandom_range(0, 63));
      else
        ra = BASE | 32'(ofs * 4) | 32'($urandom_range(0, 3));
      rw = ($urandom_range(0, 1) == 1);
      case (ofs)
        2:       rd = 32'($urandom_range(0, 6));
        3:       rd = {$urandom} & 32'hFFFF_FFF3 | 32'($urandom_range(0, 3));
        default: rd = $urandom;
      endcase
      addr = ra; wdata = rd; we = rw;
      #1;
      chk("rnd.rd", rdata, model_read(ra));
      chk("rnd.hit", 32'(hit), 32'(ra[31:6] == BASE[31:6]));
      chk("rnd.led", 32'(led), m_led);
      chk("rnd.irq", 32'(irq), 32'(m_exp));
      @(posedge clk);
      model_step(rw, ra, rd);
      #1;
      we = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
